// File: rtl/div_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_pkg
//  Description : Shared definitions for the multi-cycle MIPS DIV/DIVU
//                sequencer: FSM state encoding, default datapath width and
//                the quotient pattern returned for a zero divisor.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package div_seq_pkg;

  // Default operand/result width (MIPS GPR width).
  localparam int DEF_WIDTH = 32;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Quotient reported for a zero divisor: all ones.
  localparam logic [DEF_WIDTH-1:0] DIV0_QUO = {DEF_WIDTH{1'b1}};

endpackage : div_seq_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational radix-2 restoring divide iteration.
//                Shifts {rem,quo} left by one, trial-subtracts the divisor
//                from the shifted remainder and records the quotient bit.
//  Ports       : rem, quo, divisor   - current partial remainder, quotient
//                                      shift register and divisor magnitude
//                rem_next, quo_next  - state after this iteration
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;

  always_comb begin
    // The partial remainder is always below the divisor, so the shifted value
    // fits in WIDTH+1 bits and a non-negative difference fits in WIDTH bits.
    // Bit WIDTH of the difference is therefore exactly the borrow.
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, divisor};
    borrow   = diff[WIDTH];
    rem_next = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ~borrow};
  end

endmodule : div_step
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq
//  Description : Multi-cycle sequencer for MIPS DIV/DIVU. Runs a radix-2
//                restoring shift-subtract over WIDTH iterations while
//                stalling the pipeline, then issues a one-cycle HI/LO write
//                (remainder to HI, quotient to LO).
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous reset, active low
//                start      - divide request (sampled in IDLE only)
//                signed_div - 1 = DIV, 0 = DIVU (sampled with start)
//                cancel     - abort current/requested operation
//                dividend   - rs operand (sampled with start)
//                divisor    - rt operand (sampled with start)
//                busy       - operation in progress
//                stall_o    - pipeline stall request
//                done       - one-cycle completion pulse
//                hilo_we    - HI/LO write enable (same as done)
//                hi_o       - remainder
//                lo_o       - quotient
//  Options     : DIV_EARLY_EXIT_EN - when defined, |dividend| < |divisor|
//                with a non-zero divisor completes in one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             stall_o,
  output logic             done,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvs;
  logic               qneg;
  logic               rneg;
  logic [WIDTH-1:0]   hi_hold;
  logic [WIDTH-1:0]   lo_hold;

  logic               start_ok;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               div_zero;
  logic               early;
  logic               last_iter;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  // --------------------------------------------------------------------------
  // Operand conditioning at issue
  // --------------------------------------------------------------------------
  always_comb begin
    start_ok = (state == S_IDLE) && start && !cancel;
    a_neg    = signed_div && dividend[WIDTH-1];
    b_neg    = signed_div && divisor[WIDTH-1];
    // Two's complement negation; 0x80..0 maps to itself, which is the correct
    // unsigned magnitude and yields the architected overflow result.
    a_mag    = a_neg ? (~dividend + 1'b1) : dividend;
    b_mag    = b_neg ? (~divisor + 1'b1) : divisor;
    div_zero = (divisor == '0);
`ifdef DIV_EARLY_EXIT_EN
    early    = !div_zero && (a_mag < b_mag);
`else
    early    = 1'b0;
`endif
    last_iter = (cnt == CNT_W'(WIDTH-1));
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_next = (div_zero || early) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_iter) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (cancel) begin
      state_next = S_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Iteration datapath
  // --------------------------------------------------------------------------
  div_step #(
    .WIDTH    (WIDTH)
  ) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
      hi_hold <= '0;
      lo_hold <= '0;
    end else begin
      if (start_ok) begin
        cnt <= '0;
        dvs <= b_mag;
        if (div_zero) begin
          // Raw dividend to HI, all ones to LO; no sign fix-up applies.
          rem  <= dividend;
          quo  <= {WIDTH{DIV0_QUO[0]}};
          qneg <= 1'b0;
          rneg <= 1'b0;
        end else if (early) begin
          rem  <= a_mag;
          quo  <= '0;
          qneg <= a_neg ^ b_neg;
          rneg <= a_neg;
        end else begin
          // Dividend enters through the quotient register and is shifted
          // into the remainder one bit per iteration.
          rem  <= '0;
          quo  <= a_mag;
          qneg <= a_neg ^ b_neg;
          rneg <= a_neg;
        end
      end else if (state == S_RUN) begin
        rem <= rem_step;
        quo <= quo_step;
        cnt <= cnt + CNT_W'(1);
      end

      // Results are captured on the write cycle so they persist afterwards.
      if (done) begin
        hi_hold <= hi_fix;
        lo_hold <= lo_fix;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    hi_fix  = rneg ? (~rem + 1'b1) : rem;
    lo_fix  = qneg ? (~quo + 1'b1) : quo;
    busy    = (state != S_IDLE);
    stall_o = start_ok || (state == S_RUN);
    done    = (state == S_DONE) && !cancel;
    hilo_we = done;
    // A cancelled DONE cycle leaves the previous results visible.
    hi_o    = done ? hi_fix : hi_hold;
    lo_o    = done ? lo_fix : lo_hold;
  end

endmodule : div_seq
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_seq
//  Description : Self-checking bench for div_seq. Directed vector table,
//                hand-written cancel/reset/start-while-busy sequences and
//                randomized operations checked against an arithmetic model.
//  Options     : DIV_EARLY_EXIT_EN - expected latencies follow the macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq;

`ifdef DIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        cancel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        stall_o;
  logic        done;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  div_seq #(
    .WIDTH      (32),
    .CNT_W      (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .cancel     (cancel),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .stall_o    (stall_o),
    .done       (done),
    .hilo_we    (hilo_we),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    bit          hold;
    string       name;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with truncation toward zero.
  function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output int lat);
    longint x, y, q, r, ma, mb;
    if (b == 32'd0) begin
      hi  = a;
      lo  = 32'hFFFF_FFFF;
      lat = 1;
    end else begin
      if (sgn) begin
        x = longint'($signed(a));
        y = longint'($signed(b));
      end else begin
        x = longint'({32'd0, a});
        y = longint'({32'd0, b});
      end
      q  = x / y;
      r  = x % y;
      lo = q[31:0];
      hi = r[31:0];
      ma = (x < 0) ? -x : x;
      mb = (y < 0) ? -y : y;
      lat = (EARLY && (ma < mb)) ? 1 : 33;
    end
  endfunction

  // Entered #1 after a rising edge with the DUT idle; the current cycle is
  // cycle 0 of the operation. Leaves #1 after the edge ending cycle lat+2.
  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat, input bit hold, input string tag);
    int done_cnt;
    int done_at;
    int stall_bad;
    int we_bad;
    done_cnt  = 0;
    done_at   = -1;
    stall_bad = 0;
    we_bad    = 0;
    start      = 1'b1;
    signed_div = sgn;
    dividend   = a;
    divisor    = b;
    cancel     = 1'b0;
    for (int c = 0; c <= elat + 2; c++) begin
      #1;
      if (hilo_we !== done) we_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = c;
        chk({tag, "_hi"}, hi_o, ehi);
        chk({tag, "_lo"}, lo_o, elo);
      end
      if (stall_o !== (c < elat)) stall_bad++;
      if (c == elat + 1) chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
      if (c == elat + 2) begin
        chk({tag, "_hi_hold"}, hi_o, ehi);
        chk({tag, "_lo_hold"}, lo_o, elo);
      end
      @(posedge clk);
      #1;
      if (c == 0) begin
        // Operands must only matter in the issue cycle.
        dividend   = $urandom;
        divisor    = $urandom;
        signed_div = ~sgn;
      end
      if (!hold || c == elat - 1) start = 1'b0;
    end
    chk({tag, "_done_count"}, done_cnt, 32'd1);
    chk({tag, "_done_cycle"}, done_at, elat);
    chk({tag, "_stall_errs"}, stall_bad, 32'd0);
    chk({tag, "_we_errs"}, we_bad, 32'd0);
    last_hi = ehi;
    last_lo = elo;
  endtask

  initial begin
    int          bad;
    logic [31:0] ra, rb, rhi, rlo;
    int          rlat;
    bit          rs;
    int          sel;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         33,             1'b0, "divu_100_7"};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  33,             1'b0, "div_m7_2"};
    vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33,             1'b0, "div_ovf"};
    vecs[3] = '{1'b0, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1,              1'b0, "divu_5_0"};
    vecs[4] = '{1'b0, 32'd3,          32'd10,         32'd3,          32'd0,          EARLY ? 1 : 33, 1'b0, "divu_3_10"};
    vecs[5] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  32'hFFFF_FFFF,  1,              1'b0, "div_m7_0"};
    vecs[6] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  33,             1'b0, "div_7_m2"};
    vecs[7] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF,  33,             1'b0, "divu_max_1"};
    vecs[8] = '{1'b1, 32'hFFFF_FFFD,  32'd10,         32'hFFFF_FFFD,  32'd0,          EARLY ? 1 : 33, 1'b0, "div_m3_10"};
    vecs[9] = '{1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         33,             1'b1, "divu_hold_start"};

    rst        = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    cancel     = 1'b0;
    dividend   = 32'd0;
    divisor    = 32'd0;
    last_hi    = 32'd0;
    last_lo    = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    {31'd0, busy},    32'd0);
    chk("rst_stall",   {31'd0, stall_o}, 32'd0);
    chk("rst_done",    {31'd0, done},    32'd0);
    chk("rst_hilo_we", {31'd0, hilo_we}, 32'd0);
    chk("rst_hi",      hi_o,             32'd0);
    chk("rst_lo",      lo_o,             32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
             vecs[i].lat, vecs[i].hold, vecs[i].name);
    end

    // Cancel in cycle 10, new DIVU 9/4 issued in cycle 11
    start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    cancel = 1'b1;
    #1;
    chk("cancel_done",    {31'd0, done},    32'd0);
    chk("cancel_hilo_we", {31'd0, hilo_we}, 32'd0);
    chk("cancel_lo_hold", lo_o,             last_lo);
    @(posedge clk); #1;
    cancel = 1'b0;
    #1;
    chk("cancel_busy_low", {31'd0, busy}, 32'd0);
    run_op(1'b0, 32'd9, 32'd4, 32'd1, 32'd2, 33, 1'b0, "after_cancel");

    // Reset asserted in cycle 15 of a divide
    start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy",    {31'd0, busy},    32'd0);
    chk("midrst_stall",   {31'd0, stall_o}, 32'd0);
    chk("midrst_done",    {31'd0, done},    32'd0);
    chk("midrst_hilo_we", {31'd0, hilo_we}, 32'd0);
    chk("midrst_hi",      hi_o,             32'd0);
    chk("midrst_lo",      lo_o,             32'd0);
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (hilo_we !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("midrst_no_write", bad, 32'd0);
    last_hi = 32'd0;
    last_lo = 32'd0;

    // start together with cancel in IDLE begins nothing
    start = 1'b1; cancel = 1'b1; dividend = 32'd50; divisor = 32'd5;
    #1;
    chk("startcancel_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    #1;
    chk("startcancel_busy", {31'd0, busy}, 32'd0);
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0) bad++;
    end
    chk("startcancel_nodone", bad, 32'd0);

    // Randomized operations against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      rs  = 1'($urandom_range(0, 1));
      if (sel == 0)      rb = 32'd0;
      else if (sel <= 3) rb = $urandom_range(1, 20);
      else if (sel == 4) begin
        ra = $urandom_range(0, 1000);
        rb = $urandom_range(1001, 5000);
      end
      else               rb = $urandom;
      model(rs, ra, rb, rhi, rlo, rlat);
      run_op(rs, ra, rb, rhi, rlo, rlat, 1'b0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_div_seq
`default_nettype wire
